// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops return a registered result the
// cycle after accept; MUL runs a shift-add loop, one multiplier bit per cycle.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_INC  = 4'b0011;
  localparam logic [3:0] OP_PSA  = 4'b0100;
  localparam logic [3:0] OP_PSB  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_nx;
  logic             load_alu, load_mul, mul_last, accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_e;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_step;
  logic [SHW-1:0]   cnt;

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready.
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sh       = B[SHW-1:0];
  assign acc_step = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (func)
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, A} + {1'b0, B};
        alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow.
        {alu_c, alu_res} = {1'b0, A} - {1'b0, B};
        alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_NAND: alu_res = ~(A & B);
      OP_INC: begin
        {alu_c, alu_res} = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
        alu_v = !A[WIDTH-1] && alu_res[WIDTH-1];
      end
      OP_PSA:  alu_res = A;
      OP_PSB:  alu_res = B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLL:  alu_res = A << sh;
      OP_SRL:  alu_res = A >> sh;
      OP_SRA:  alu_res = $signed(A) >>> sh;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_MUL:  alu_res = '0;
      default: alu_e = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    load_alu = 1'b0;
    load_mul = 1'b0;
    mul_last = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (func == OP_MUL) begin
            load_mul = 1'b1;
            state_nx = MUL;
          end else begin
            load_alu = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt == SHW'(WIDTH-1)) begin
          mul_last = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nx;
      if (load_alu) begin
        out       <= alu_res;
        zero      <= (alu_res == '0);
        neg       <= alu_res[WIDTH-1];
        carry     <= alu_c;
        ovf       <= alu_v;
        err       <= alu_e;
        out_valid <= 1'b1;
      end else if (mul_last) begin
        out       <= acc_step;
        zero      <= (acc_step == '0);
        neg       <= acc_step[WIDTH-1];
        carry     <= 1'b0;
        ovf       <= 1'b0;
        err       <= 1'b0;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (load_mul) begin
        mcand  <= A;
        mplier <= B;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == MUL) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + SHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases, randomized ops with
// random backpressure, and a reference model built from plain 64-bit arithmetic.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  func;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        zero, neg, carry, ovf, err;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .func(func), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish within 50000 cycles");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- reference model ----------------
  // Packed as {err, ovf, carry, neg, zero, out}.
  function automatic logic [36:0] model(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
    longint unsigned ux, uy, full;
    longint sx, sy, r_s, tmp;
    logic [31:0] r;
    bit c, v, e;
    int sh;
    ux = x; uy = y;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y & 32'd31);
    c = 0; v = 0; e = 0; r = 32'd0; r_s = 0;
    case (f)
      4'd0:  begin full = ux + uy; r = full[31:0]; c = (full > 64'hFFFF_FFFF); r_s = sx + sy; v = (r_s != longint'($signed(r))); end
      4'd1:  begin r = x - y; c = (ux < uy); r_s = sx - sy; v = (r_s != longint'($signed(r))); end
      4'd2:  r = ~(x & y);
      4'd3:  begin full = ux + 1; r = full[31:0]; c = (full > 64'hFFFF_FFFF); r_s = sx + 1; v = (r_s != longint'($signed(r))); end
      4'd4:  r = x;
      4'd5:  r = y;
      4'd6:  r = x & y;
      4'd7:  r = x | y;
      4'd8:  r = x ^ y;
      4'd9:  r = x << sh;
      4'd10: r = x >> sh;
      4'd11: begin tmp = sx >>> sh; r = tmp[31:0]; end
      4'd12: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd13: begin full = ux * uy; r = full[31:0]; end
      default: begin r = 32'd0; e = 1; end
    endcase
    return {e, v, c, r[31], (r == 32'd0), r};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every result handed over must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_result: observed out=%h with no expected entry", out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {27'd0, err, ovf, carry, neg, zero, out}, {27'd0, mon_exp});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y, input bit rnd);
    int n;
    exp_q.push_back(model(f, x, y));
    func = f; a = x; b = y; in_valid = 1'b1;
    n = 0;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    while (!in_ready && n < 200) begin
      step();
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed in_ready=0 for %0d cycles, expected accept", n);
    end
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; func = 4'($urandom);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; func = '0;
    step(); step();
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", {zero, neg, carry, ovf, err}, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // ADD wraparound
    send(4'h0, 32'hFFFF_FFFF, 32'h1, 0);
    check("add_valid", out_valid, 1);
    check("add_out", out, 0);
    check("add_zc_v", {zero, carry, ovf}, 3'b110);

    // SUB overflow and borrow
    send(4'h1, 32'h8000_0000, 32'h1, 0);
    check("sub_ovf_out", out, 32'h7FFF_FFFF);
    check("sub_ovf_flags", {ovf, neg, carry}, 3'b100);
    send(4'h1, 32'd3, 32'd5, 0);
    check("sub_borrow_out", out, 32'hFFFF_FFFE);
    check("sub_borrow_flags", {carry, neg}, 2'b11);

    // shifts use only the low bits of B
    send(4'hB, 32'h8000_0000, 32'h21, 0);
    check("sra", out, 32'hC000_0000);
    send(4'hA, 32'h8000_0000, 32'h21, 0);
    check("srl", out, 32'h4000_0000);
    send(4'h9, 32'h8000_0000, 32'h21, 0);
    check("sll", out, 0);
    send(4'hC, 32'hFFFF_FFFF, 32'h1, 0);
    check("slt", out, 1);

    // MUL latency with a competing request held the whole time
    send(4'hD, 32'h0001_2345, 32'h0000_0100, 0);
    in_valid = 1'b1; func = 4'h0; a = 32'd1; b = 32'd2;
    for (int i = 0; i < 32; i++) begin
      check("mul_in_ready_low", in_ready, 0);
      check("mul_busy_valid", out_valid, 0);
      step();
    end
    check("mul_valid", out_valid, 1);
    check("mul_out", out, 32'h0123_4500);
    check("mul_in_ready_back", in_ready, 1);
    send(4'h0, 32'd1, 32'd2, 0);
    step();

    // backpressure: result holds, next op goes back-to-back on release
    out_ready = 1'b0;
    send(4'h3, 32'd7, 32'd0, 0);
    in_valid = 1'b1; func = 4'h5; a = 32'hDEAD_BEEF; b = 32'h55;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_out_hold", out, 32'd8);
      check("bp_valid_hold", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    exp_q.push_back(model(4'h5, 32'hDEAD_BEEF, 32'h55));
    step();
    in_valid = 1'b0;
    check("bp_b2b_out", out, 32'h55);
    check("bp_b2b_valid", out_valid, 1);
    step();

    // randomized ops with random backpressure
    for (int i = 0; i < 120; i++) begin
      logic [3:0] f;
      f = 4'($urandom_range(0, 15));
      if (f == 4'hD && $urandom_range(0, 3) != 0) f = 4'($urandom_range(0, 12));
      send(f, pick_operand(), pick_operand(), 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    check("random_drained", exp_q.size(), 0);

    // reset in the middle of a multiply
    send(4'h4, 32'h0000_DEAD, 32'h0, 0);
    step();
    send(4'hD, $urandom, $urandom, 0);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    #1;
    check("midmul_rst_valid", out_valid, 0);
    check("midmul_rst_out", out, 0);
    check("midmul_rst_flags", {zero, neg, carry, ovf, err}, 0);
    exp_q.delete();
    step(); step();
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);
    send(4'hF, $urandom, $urandom, 0);
    check("illegal_out", out, 0);
    check("illegal_err_zero", {err, zero, neg, carry, ovf}, 5'b11000);
    check("illegal_valid", out_valid, 1);
    step(); step();
    check("final_drained", exp_q.size(), 0);
    check("final_idle_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational 32-bit `alu`. It executes one operation per accepted request: single-cycle ops return a registered result one cycle later, and multiply runs iteratively (shift-add, one bit per cycle). It sits between the decode/operand-fetch stage and writeback in MY-P0. Valid/ready handshakes let the datapath stall on either side, and it adds status flags and an error indication.

## Interface
- `WIDTH`, 32: operand/result width. Must be a power of 2 and at least 8.
- `SHW`, `$clog2(WIDTH)`: shift-amount width (derived; do not override).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request this cycle.
- `A`, `B`  in  WIDTH  operands; sampled on accept.
- `func`  in  4  opcode; sampled on accept.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out`  out  WIDTH  registered result.
- `zero`, `neg`, `carry`, `ovf`, `err`  out  1 each  registered flags, valid with `out_valid`.

## Operation
- Opcodes; 0000–0101 keep the legacy `alu` encoding:
  - 0000 ADD A+B
  - 0001 SUB A−B
  - 0010 NAND ~(A&B)
  - 0011 INC A+1
  - 0100 PASS A
  - 0101 PASS B
  - 0110 AND
  - 0111 OR
  - 1000 XOR
  - 1001 SLL A<<B[SHW-1:0]
  - 1010 SRL
  - 1011 SRA (arithmetic)
  - 1100 SLT: 1 if signed A<B, else 0
  - 1101 MUL: low WIDTH bits of A*B
  - 1110/1111 illegal: `out`=0, `err`=1, other flags computed on 0. No Z outputs.
- Arithmetic is modulo 2^WIDTH. Only the low SHW bits of B are used as the shift amount; upper B bits are ignored.
- Flags:
  - `zero` = (out==0).
  - `neg` = out[WIDTH-1].
  - `carry`: carry-out for ADD/INC; borrow for SUB (1 when A<B unsigned); 0 otherwise.
  - `ovf`: signed overflow for ADD/SUB/INC; 0 otherwise.
  - `err` = 1 only for illegal opcodes.
- FSM states:
  - IDLE: accept when `in_valid && in_ready`. A non-MUL op loads `out`/flags, sets `out_valid`, and stays in IDLE. MUL loads the multiplicand, multiplier, accumulator=0 and counter=0, then goes to MUL.
  - MUL: each cycle, if multiplier[0] then acc+=multiplicand; multiplicand<<=1, multiplier>>=1, count++. After WIDTH iterations, load `out`/flags and set `out_valid`; the cycle after the last iteration the FSM goes to IDLE.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready). In IDLE, a new result may replace one being consumed in the same cycle, giving back-to-back throughput.
- The output holds: `out`, the flags and `out_valid` are stable while `out_valid && !out_ready`. `out_valid` clears on the handshake unless a new result loads that same edge.
- Reset (async, any time, including mid-MUL): state=IDLE, `out`=0, all flags 0, `out_valid`=0, and any multiply in progress is aborted and lost. `in_ready` is 1 after reset deasserts.

## Timing
- Single-cycle ops: accepted at edge N, `out_valid`=1 after edge N; one result per cycle while `out_ready`=1.
- MUL: accepted at edge N, result valid after edge N+WIDTH (32 cycles at default). `in_ready`=0 during MUL and until the MUL result is consumed.
- Inputs are sampled only on the accept edge; operand changes afterwards have no effect.
- No combinational path from `in_valid`/`A`/`B`/`func` to any output. `in_ready` depends combinationally on `out_ready`.

## Test plan
- Reset then ADD 0xFFFFFFFF+1 (WIDTH=32): the cycle after accept, `out`=0, `zero`=1, `carry`=1, `ovf`=0.
- SUB 0x80000000−1: `out`=0x7FFFFFFF, `ovf`=1, `neg`=0, `carry`=0. SUB 3−5: `out`=0xFFFFFFFE, `carry`=1, `neg`=1.
- Shifts with A=0x80000000, B=0x21 (amount 1): SRA→0xC0000000, SRL→0x40000000, SLL→0. SLT with A=−1, B=1 → 1.
- MUL 0x12345×0x100 with `out_ready`=1: `in_ready`=0 for 32 cycles, then `out`=0x1234500 with `out_valid`; a second request in the same cycle is refused.
- Backpressure: issue INC 7 with `out_ready`=0 for 5 cycles. `out`=8 is held stable and `in_ready`=0. The cycle `out_ready` rises, the next op is accepted back-to-back.
- Assert `rst` at cycle 10 of a MUL: `out_valid`=0 and `out`=0 immediately. After release, `func`=1111 gives `err`=1, `out`=0, `zero`=1.
